intersection_light_ctrl: RTL and testbench

//  Two-road intersection scheduler. Sequences a main road (NS) and a side road (EW) through

---
 rtl/intersection_light_ctrl_pkg.sv | 19 +
 rtl/intersection_light_ctrl_phase_timer.sv | 27 ++
 rtl/intersection_light_ctrl.sv | 114 +++++++++++
 tb/tb_intersection_light_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/intersection_light_ctrl_pkg.sv
// rtl/intersection_light_ctrl_pkg.sv - light codes and phase encodings for the intersection scheduler
package intersection_light_ctrl_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b001;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        AR_NS     = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        AR_EW     = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5
    } state_t;

endpackage

// File: rtl/intersection_light_ctrl_phase_timer.sv
// rtl/intersection_light_ctrl_phase_timer.sv - loadable down-counter that saturates at zero
module intersection_light_ctrl_phase_timer #(
    parameter int CNT_W   = 8,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= CNT_W'(RST_VAL);
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/intersection_light_ctrl.sv
// rtl/intersection_light_ctrl.sv - NS/EW phase sequencer with sensor and pedestrian service
module intersection_light_ctrl
    import intersection_light_ctrl_pkg::*;
#(
    parameter int NS_GREEN_CYC = 8,
    parameter int EW_GREEN_CYC = 6,
    parameter int YELLOW_CYC   = 2,
    parameter int ALLRED_CYC   = 1,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ew_sensor,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ped_walk,
    output logic [2:0] phase
);

    state_t           r_state;
    state_t           w_next;
    logic             r_ped_pending;
    logic             w_expired;
    logic             w_reload;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic [2:0]       r_ns_light;
    logic [2:0]       r_ew_light;
    logic             r_ped_walk;
    logic [2:0]       w_ns_light;
    logic [2:0]       w_ew_light;

    intersection_light_ctrl_phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_CYC - 1)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_expired  (w_expired)
    );

    always_comb begin
        w_next   = r_state;
        w_reload = 1'b0;
        case (r_state)
            AR_NS:     if (w_expired) w_next = NS_GREEN;
            NS_GREEN:  if (w_expired && (ew_sensor || r_ped_pending)) w_next = NS_YELLOW;
            NS_YELLOW: if (w_expired) w_next = AR_EW;
            AR_EW:     if (w_expired) w_next = EW_GREEN;
            EW_GREEN:  if (w_expired) w_next = EW_YELLOW;
            EW_YELLOW: if (w_expired) w_next = AR_NS;
            default: begin
                w_next   = AR_NS;
                w_reload = 1'b1;
            end
        endcase
    end

    // Timer reloads on every phase change so the count always refers to the new phase.
    always_comb begin
        w_load = w_reload || (w_next != r_state);
        case (w_next)
            NS_GREEN:             w_load_val = CNT_W'(NS_GREEN_CYC - 1);
            EW_GREEN:             w_load_val = CNT_W'(EW_GREEN_CYC - 1);
            NS_YELLOW, EW_YELLOW: w_load_val = CNT_W'(YELLOW_CYC - 1);
            default:              w_load_val = CNT_W'(ALLRED_CYC - 1);
        endcase
    end

    always_comb begin
        w_ns_light = LIGHT_RED;
        w_ew_light = LIGHT_RED;
        case (w_next)
            NS_GREEN:  w_ns_light = LIGHT_GREEN;
            NS_YELLOW: w_ns_light = LIGHT_YELLOW;
            EW_GREEN:  w_ew_light = LIGHT_GREEN;
            EW_YELLOW: w_ew_light = LIGHT_YELLOW;
            default: begin
                w_ns_light = LIGHT_RED;
                w_ew_light = LIGHT_RED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= AR_NS;
            r_ped_pending <= 1'b0;
            r_ns_light    <= LIGHT_RED;
            r_ew_light    <= LIGHT_RED;
            r_ped_walk    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_ns_light <= w_ns_light;
            r_ew_light <= w_ew_light;
            r_ped_walk <= (w_next == EW_GREEN);
            // Entering EW green serves the request, even one arriving on that same edge.
            if (w_next == EW_GREEN && r_state != EW_GREEN) begin
                r_ped_pending <= 1'b0;
            end else if (ped_req) begin
                r_ped_pending <= 1'b1;
            end
        end
    end

    assign ns_light = r_ns_light;
    assign ew_light = r_ew_light;
    assign ped_walk = r_ped_walk;
    assign phase    = r_state;

endmodule

// File: tb/tb_intersection_light_ctrl.sv
// tb/tb_intersection_light_ctrl.sv - directed self-checking bench for intersection_light_ctrl
module tb_intersection_light_ctrl;
    import intersection_light_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic       ew_sensor;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ped_walk;
    logic [2:0] phase;

    int n_chk = 0;
    int n_err = 0;
    logic mon_en = 1'b0;

    intersection_light_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .ew_sensor (ew_sensor),
        .ped_req   (ped_req),
        .ns_light  (ns_light),
        .ew_light  (ew_light),
        .ped_walk  (ped_walk),
        .phase     (phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected phase at edge k after reset release, given how many EW services occur.
    function automatic logic [2:0] exp_phase(input int k, input int nserv);
        int n;
        int idx;
        n   = (k - 1) / 20;
        idx = (k - 1) % 20;
        if (n >= nserv) return 3'd1;
        if (idx < 8)   return 3'd1;
        if (idx < 10)  return 3'd2;
        if (idx == 10) return 3'd3;
        if (idx < 17)  return 3'd4;
        if (idx < 19)  return 3'd5;
        return 3'd0;
    endfunction

    function automatic logic [9:0] exp_vec(input logic [2:0] ph);
        logic [2:0] ns;
        logic [2:0] ew;
        ns = (ph == 3'd1) ? 3'b010 : (ph == 3'd2) ? 3'b001 : 3'b100;
        ew = (ph == 3'd4) ? 3'b010 : (ph == 3'd5) ? 3'b001 : 3'b100;
        return {ph, ns, ew, (ph == 3'd4)};
    endfunction

    task automatic do_reset(input logic sensor);
        rst       = 1'b1;
        ew_sensor = sensor;
        ped_req   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_seq(input string tag, input int nserv, input int nedges,
                           input int pf, input int pt);
        for (int k = 1; k <= nedges; k++) begin
            ped_req = (k >= pf && k <= pt);
            tick();
            check($sformatf("%s_e%0d", tag, k), {phase, ns_light, ew_light, ped_walk},
                  exp_vec(exp_phase(k, nserv)));
        end
        ped_req = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst)
            check("never_both_nonred", (ns_light != 3'b100) && (ew_light != 3'b100), 1'b0);
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        ew_sensor = 1'b0;
        ped_req   = 1'b0;
        #1;
        check("reset_state", {phase, ns_light, ew_light, ped_walk}, {3'd0, 3'b100, 3'b100, 1'b0});
        mon_en = 1'b1;

        do_reset(1'b0);
        run_seq("rest", 0, 50, 0, -1);

        do_reset(1'b1);
        run_seq("sensor", 100, 40, 0, -1);

        do_reset(1'b0);
        run_seq("ped_pulse", 1, 40, 4, 4);

        do_reset(1'b0);
        run_seq("ped_clear_wins", 1, 40, 1, 12);

        do_reset(1'b0);
        run_seq("ped_held", 2, 50, 1, 13);

        do_reset(1'b1);
        run_seq("pre_rst", 100, 14, 13, 13);
        ew_sensor = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_mid_ewg", {phase, ns_light, ew_light, ped_walk}, {3'd0, 3'b100, 3'b100, 1'b0});
        tick();
        check("rst_held", {phase, ns_light, ew_light, ped_walk}, {3'd0, 3'b100, 3'b100, 1'b0});
        rst = 1'b0;
        tick();
        check("rst_release_nsg", {phase, ns_light, ew_light, ped_walk}, {3'd1, 3'b010, 3'b100, 1'b0});
        run_seq("post_rst_rest", 0, 20, 0, -1);

        force dut.r_state = state_t'(3'd7);
        #1;
        release dut.r_state;
        check("illegal_forced", phase, 3'd7);
        tick();
        check("illegal_recover", {phase, ns_light, ew_light, ped_walk}, {3'd0, 3'b100, 3'b100, 1'b0});
        tick();
        check("illegal_then_nsg", {phase, ns_light, ew_light, ped_walk}, {3'd1, 3'b010, 3'b100, 1'b0});

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
